clause_bin_loader: RTL and testbench
====================================

# clause_bin_loader

Upstream feeder of `clause_array`. On `start_i` it fetches one bin of clauses from clause memory and writes them row by row into the array over its `wr_i`/`clause_len_i`/`var_value_i` port. It computes each clause length and zero-fills unused rows. Between bin loads it also inserts a single learnt clause at the one-hot slot reported by the array's `learntc_insert_index_o`.

## Interface
- `NUM_CLAUSES`, 8, rows in the clause array
- `NUM_VARS`, 8, variables per bin
- `WIDTH_C_LEN`, 4, clause-length width; `clause_len_o` is `WIDTH_C_LEN+1` bits
- `ADDR_W`, 8, clause-memory address width
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start_i`  in  1  begin bin load, sampled in IDLE only
- `base_addr_i`  in  `ADDR_W`  memory address of row 0, latched on start
- `n_clauses_i`  in  `$clog2(NUM_CLAUSES+1)`  valid clauses in bin; values >`NUM_CLAUSES` clamp to `NUM_CLAUSES`
- `mem_rd_o`  out  1  one-cycle read strobe
- `mem_addr_o`  out  `ADDR_W`  read address
- `mem_rdata_i`  in  `NUM_VARS*2`  row of 2-bit literal codes
- `mem_rvalid_i`  in  1  read data valid, latency ≥1 cycle; one read outstanding
- `wr_o`  out  `NUM_CLAUSES`  one-hot row write to clause_array
- `clause_len_o`  out  `WIDTH_C_LEN+1`  literal count of written row
- `var_value_o`  out  `NUM_VARS*3`  per var `{1'b0, code}`
- `learnt_req_i`  in  1  learnt clause pending, sampled in IDLE
- `learnt_lits_i`  in  `NUM_VARS*2`  learnt clause literal codes
- `insert_index_i`  in  `NUM_CLAUSES`  free-slot vector from clause_array
- `learnt_ack_o`  out  1  pulse: learnt clause written
- `learnt_full_o`  out  1  pulse: no free slot, clause dropped
- `busy_o`  out  1  state ≠ IDLE
- `done_o`  out  1  pulse: bin load complete

## Operation
- Literal codes: 0 none, 1 positive, 2 negative, 3 reserved. Code 3 is written as 0 and not counted.
- `clause_len_o` = count of codes 1/2 in the row (0..`NUM_VARS`).
- FSM states: IDLE, REQ, WAIT, WRITE, CLEAR, LWRITE, DONE.
- IDLE:
  - `start_i` → latch base and clamped n; row=0; go to REQ if n>0, else CLEAR.
  - Otherwise `learnt_req_i` → LWRITE if `insert_index_i`≠0; else pulse `learnt_full_o` next cycle and stay in IDLE.
  - `start_i` beats `learnt_req_i` when both are high.
- REQ: `mem_rd_o`=1, `mem_addr_o`=base+row (mod 2^`ADDR_W`) → WAIT.
- WAIT: hold until `mem_rvalid_i`, capture data → WRITE. `mem_rvalid_i` in any other state is ignored.
- WRITE:
  - `wr_o`=one-hot(row), with len and values, for exactly one cycle; row++.
  - Next state: REQ if row<n, CLEAR if n<`NUM_CLAUSES`, else DONE.
- CLEAR: one row per cycle, `wr_o` one-hot, len 0, values 0. After row `NUM_CLAUSES-1` → DONE.
- LWRITE: `wr_o` = lowest set bit of the latched `insert_index_i`, data from latched `learnt_lits_i`, `learnt_ack_o`=1 → IDLE.
- DONE: `done_o`=1 → IDLE.
- `start_i` and `learnt_req_i` while busy are ignored (not queued).

## Timing
- All outputs are registered. Reset value of every output is 0 (`mem_addr_o`=0, `wr_o`=0).
- With 1-cycle memory latency each clause takes 3 cycles (REQ, WAIT, WRITE) and each cleared row takes 1 cycle.
- `done_o` is high 3n+(`NUM_CLAUSES`−n)+1 cycles after the start sampling edge:
  - n=5 → 19
  - n=8 → 25
  - n=0 → 9
- Learnt insert: `wr_o` and `learnt_ack_o` are high the cycle after `learnt_req_i` is sampled.
- `wr_o` is never multi-hot and is never asserted in IDLE, REQ, WAIT or DONE.
- Reset mid-load: outputs clear asynchronously and the FSM returns to IDLE. No partial row is written after reset asserts, and any read return in flight is dropped.

## Structure
- Shared package `sat_pkg`:
  - literal code constants `LIT_NONE`, `LIT_POS`, `LIT_NEG`
  - loader state enum
  - 3-bit var-value field width
- One sub-module, `lit_row_pack`: combinational code sanitize, 2→3-bit expansion and popcount. It is instantiated once; its input is muxed between memory data and learnt literals.

## Test plan
- Bin with 5 clauses, e.g. row0 codes {2,0,1,0,0,0,0,0}, 1-cycle memory → rows 0..4 written with lens 2,3,3,3,3; rows 5..7 written len 0 and values 0; `done_o` at cycle 19; array `learntc_insert_index_o`=8'b0010_0000.
- Full 8-clause bin with memory latency 3 → eight writes in order, no CLEAR; done at 8·5+1=41 cycles; `mem_addr_o` increments from base with wrap at base=8'hFE.
- Learnt clause {1,0,1,0,0,1,2,0} with `insert_index_i`=8'b0010_0000 → next cycle `wr_o`=8'b0010_0000, len 4, `learnt_ack_o`=1.
- `insert_index_i`=0 with `learnt_req_i` → `learnt_full_o` pulse, `wr_o` stays 0; `start_i` and `learnt_req_i` in the same cycle → load runs, learnt request ignored.
- Code-3 literals → written as 0 and not counted; n_clauses_i=12 clamps to 8.
- `rst` low during WAIT → all outputs 0 immediately; a late `mem_rvalid_i` causes no write; a new start after release loads cleanly.

Source files
------------

// File: rtl/sat_pkg.sv
// Shared literal codes, loader state encoding and field widths for the clause array path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sat_pkg;

  // Two-bit literal code per variable as stored in clause memory
  localparam int LIT_W = 2;
  localparam logic [LIT_W-1:0] LIT_NONE = 2'd0;
  localparam logic [LIT_W-1:0] LIT_POS  = 2'd1;
  localparam logic [LIT_W-1:0] LIT_NEG  = 2'd2;

  // Per-variable value field expected by clause_array: {1'b0, code}
  localparam int VAR_VAL_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_WRITE,
    ST_CLEAR,
    ST_LWRITE,
    ST_DONE
  } loader_state_e;

endpackage

// File: rtl/clause_bin_loader_if.sv
// Bundles the loader's control, clause-memory read port and clause_array write port.
// Latency: n/a (wiring only).
// Backpressure: none; the memory side is a strobe/valid pair with one read outstanding.
interface clause_bin_loader_if #(
  parameter int NUM_CLAUSES = 8,
  parameter int NUM_VARS    = 8,
  parameter int WIDTH_C_LEN = 4,
  parameter int ADDR_W      = 8
);
  import sat_pkg::*;

  localparam int CNT_W = $clog2(NUM_CLAUSES + 1);

  // Control
  logic                           start_i;
  logic [ADDR_W-1:0]              base_addr_i;
  logic [CNT_W-1:0]               n_clauses_i;
  logic                           busy_o;
  logic                           done_o;

  // Clause memory read port
  logic                           mem_rd_o;
  logic [ADDR_W-1:0]              mem_addr_o;
  logic [NUM_VARS*LIT_W-1:0]      mem_rdata_i;
  logic                           mem_rvalid_i;

  // clause_array write port
  logic [NUM_CLAUSES-1:0]         wr_o;
  logic [WIDTH_C_LEN:0]           clause_len_o;
  logic [NUM_VARS*VAR_VAL_W-1:0]  var_value_o;

  // Learnt clause insertion
  logic                           learnt_req_i;
  logic [NUM_VARS*LIT_W-1:0]      learnt_lits_i;
  logic [NUM_CLAUSES-1:0]         insert_index_i;
  logic                           learnt_ack_o;
  logic                           learnt_full_o;

  // Loader side
  modport master (
    input  start_i, base_addr_i, n_clauses_i,
    input  mem_rdata_i, mem_rvalid_i,
    input  learnt_req_i, learnt_lits_i, insert_index_i,
    output busy_o, done_o,
    output mem_rd_o, mem_addr_o,
    output wr_o, clause_len_o, var_value_o,
    output learnt_ack_o, learnt_full_o
  );

  // Environment side (memory, clause_array, solver control)
  modport slave (
    output start_i, base_addr_i, n_clauses_i,
    output mem_rdata_i, mem_rvalid_i,
    output learnt_req_i, learnt_lits_i, insert_index_i,
    input  busy_o, done_o,
    input  mem_rd_o, mem_addr_o,
    input  wr_o, clause_len_o, var_value_o,
    input  learnt_ack_o, learnt_full_o
  );

endinterface

// File: rtl/lit_row_pack.sv
// Sanitizes a row of 2-bit literal codes, expands each to 3 bits and counts live literals.
// Latency: combinational.
// Backpressure: none.
module lit_row_pack
  import sat_pkg::*;
#(
  parameter int NUM_VARS    = 8,
  parameter int WIDTH_C_LEN = 4
) (
  input  logic [NUM_VARS*LIT_W-1:0]     lits_i,
  output logic [NUM_VARS*VAR_VAL_W-1:0] var_value_o,
  output logic [WIDTH_C_LEN:0]          clause_len_o
);

  localparam int LEN_W = WIDTH_C_LEN + 1;

  // Reserved code 3 collapses to "none" so it neither reaches the array nor counts
  always_comb begin
    var_value_o  = '0;
    clause_len_o = '0;
    for (int i = 0; i < NUM_VARS; i++) begin
      if ((lits_i[i*LIT_W +: LIT_W] == LIT_POS) || (lits_i[i*LIT_W +: LIT_W] == LIT_NEG)) begin
        var_value_o[i*VAR_VAL_W +: VAR_VAL_W] = {1'b0, lits_i[i*LIT_W +: LIT_W]};
        clause_len_o = clause_len_o + LEN_W'(1);
      end else begin
        var_value_o[i*VAR_VAL_W +: VAR_VAL_W] = {1'b0, LIT_NONE};
      end
    end
  end

endmodule

// File: rtl/clause_bin_loader.sv
// Loads one bin of clauses from clause memory into clause_array, zero-fills spare rows, and inserts learnt clauses.
// Latency: 3 cycles per clause at 1-cycle memory latency, 1 per cleared row, +1 for done; learnt write 1 cycle.
// Backpressure: none downstream; waits on mem_rvalid_i with one read outstanding; start/learnt requests while busy are dropped.
module clause_bin_loader
  import sat_pkg::*;
#(
  parameter int NUM_CLAUSES = 8,
  parameter int NUM_VARS    = 8,
  parameter int WIDTH_C_LEN = 4,
  parameter int ADDR_W      = 8
) (
  input  logic          clk,
  input  logic          rst,
  clause_bin_loader_if.master bus
);

  localparam int CNT_W = $clog2(NUM_CLAUSES + 1);

  loader_state_e                  state_q;
  logic [ADDR_W-1:0]              base_q;
  logic [CNT_W-1:0]               n_q;
  logic [CNT_W-1:0]               row_q;

  logic                           mem_rd_q;
  logic [ADDR_W-1:0]              mem_addr_q;
  logic [NUM_CLAUSES-1:0]         wr_q;
  logic [WIDTH_C_LEN:0]           len_q;
  logic [NUM_VARS*VAR_VAL_W-1:0]  vv_q;
  logic                           ack_q;
  logic                           full_q;
  logic                           busy_q;
  logic                           done_q;

  logic [NUM_VARS*LIT_W-1:0]      pack_in;
  logic [NUM_VARS*VAR_VAL_W-1:0]  pack_vv;
  logic [WIDTH_C_LEN:0]           pack_len;
  logic [CNT_W-1:0]               n_clamp_d;
  logic [CNT_W-1:0]               row_d;
  logic [NUM_CLAUSES-1:0]         lowest_slot_d;

  function automatic logic [NUM_CLAUSES-1:0] row_onehot(input logic [CNT_W-1:0] r);
    row_onehot = {{(NUM_CLAUSES-1){1'b0}}, 1'b1} << r;
  endfunction

  // Learnt literals are only consumed on the IDLE->LWRITE edge; every other capture is memory data
  assign pack_in = (state_q == ST_IDLE) ? bus.learnt_lits_i : bus.mem_rdata_i;

  lit_row_pack #(
    .NUM_VARS    (NUM_VARS),
    .WIDTH_C_LEN (WIDTH_C_LEN)
  ) u_pack (
    .lits_i       (pack_in),
    .var_value_o  (pack_vv),
    .clause_len_o (pack_len)
  );

  assign n_clamp_d     = (bus.n_clauses_i > CNT_W'(NUM_CLAUSES)) ? CNT_W'(NUM_CLAUSES) : bus.n_clauses_i;
  assign row_d         = row_q + CNT_W'(1);
  // Two's-complement trick isolates the lowest free slot so the write is always one-hot
  assign lowest_slot_d = bus.insert_index_i & (~bus.insert_index_i + NUM_CLAUSES'(1));

  // Loader FSM; every output is set on the edge that enters the state it belongs to
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      n_q        <= '0;
      row_q      <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      wr_q       <= '0;
      len_q      <= '0;
      vv_q       <= '0;
      ack_q      <= 1'b0;
      full_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      mem_rd_q <= 1'b0;
      wr_q     <= '0;
      len_q    <= '0;
      vv_q     <= '0;
      ack_q    <= 1'b0;
      full_q   <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start_i) begin
            base_q <= bus.base_addr_i;
            n_q    <= n_clamp_d;
            row_q  <= '0;
            busy_q <= 1'b1;
            if (n_clamp_d != '0) begin
              state_q    <= ST_REQ;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= bus.base_addr_i;
            end else begin
              state_q <= ST_CLEAR;
              wr_q    <= row_onehot('0);
            end
          end else if (bus.learnt_req_i) begin
            if (bus.insert_index_i != '0) begin
              state_q <= ST_LWRITE;
              busy_q  <= 1'b1;
              wr_q    <= lowest_slot_d;
              len_q   <= pack_len;
              vv_q    <= pack_vv;
              ack_q   <= 1'b1;
            end else begin
              full_q <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.mem_rvalid_i) begin
            state_q <= ST_WRITE;
            wr_q    <= row_onehot(row_q);
            len_q   <= pack_len;
            vv_q    <= pack_vv;
          end
        end
        ST_WRITE: begin
          row_q <= row_d;
          if (row_d < n_q) begin
            state_q    <= ST_REQ;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= base_q + ADDR_W'(row_d);
          end else if (n_q < CNT_W'(NUM_CLAUSES)) begin
            state_q <= ST_CLEAR;
            wr_q    <= row_onehot(row_d);
          end else begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (row_q == CNT_W'(NUM_CLAUSES - 1)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            row_q <= row_d;
            wr_q  <= row_onehot(row_d);
          end
        end
        ST_LWRITE, ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_rd_o      = mem_rd_q;
  assign bus.mem_addr_o    = mem_addr_q;
  assign bus.wr_o          = wr_q;
  assign bus.clause_len_o  = len_q;
  assign bus.var_value_o   = vv_q;
  assign bus.learnt_ack_o  = ack_q;
  assign bus.learnt_full_o = full_q;
  assign bus.busy_o        = busy_q;
  assign bus.done_o        = done_q;

endmodule

// File: tb/tb_clause_bin_loader.sv
// Directed bench for clause_bin_loader with a latency-configurable clause memory model.
// Latency: n/a.
// Backpressure: memory model answers one read at a time after mem_lat cycles.
module tb_clause_bin_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;

  clause_bin_loader_if bus ();

  clause_bin_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int ack_cnt = 0;
  int multihot = 0;
  int mem_lat = 1;

  logic [15:0] mem [256];
  logic [7:0]  maddr;

  logic [7:0]  wr_log[$];
  logic [4:0]  len_log[$];
  logic [23:0] vv_log[$];
  logic [7:0]  addr_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Clause memory: answers the read strobe after mem_lat cycles
  initial begin
    forever begin
      @(negedge clk);
      if (bus.mem_rd_o) begin
        maddr = bus.mem_addr_o;
        @(posedge clk);
        repeat (mem_lat - 1) @(posedge clk);
        #1;
        bus.mem_rdata_i  = mem[maddr];
        bus.mem_rvalid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
      end
    end
  end

  // Output monitor
  always @(negedge clk) begin
    if (bus.wr_o != 8'h00) begin
      wr_log.push_back(bus.wr_o);
      len_log.push_back(bus.clause_len_o);
      vv_log.push_back(bus.var_value_o);
      if ($countones(bus.wr_o) != 1) multihot++;
    end
    if (bus.mem_rd_o) addr_log.push_back(bus.mem_addr_o);
    if (bus.learnt_ack_o) ack_cnt++;
    if (bus.done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic clear_logs();
    wr_log.delete();
    len_log.delete();
    vv_log.delete();
    addr_log.delete();
    done_cnt = 0;
    ack_cnt  = 0;
    multihot = 0;
  endtask

  task automatic do_start(input logic [7:0] base, input logic [3:0] n);
    bus.base_addr_i = base;
    bus.n_clauses_i = n;
    bus.start_i     = 1'b1;
    @(posedge clk);
    #1;
    start_cyc   = cyc;
    bus.start_i = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int n;
    n = 0;
    while (done_cnt < target && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (done_cnt < target) begin
      errors++;
      $display("FAIL %s_timeout: done seen %0d times after %0d cycles, required %0d", name, done_cnt, n, target);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.wr_o !== 8'h00) begin errors++; $display("FAIL reset_wr: got %h want 00", bus.wr_o); end
    checks++;
    if (bus.mem_addr_o !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h want 00", bus.mem_addr_o); end
    checks++;
    if ({bus.mem_rd_o, bus.busy_o, bus.done_o, bus.learnt_ack_o, bus.learnt_full_o} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000",
                         {bus.mem_rd_o, bus.busy_o, bus.done_o, bus.learnt_ack_o, bus.learnt_full_o});
    end
    checks++;
    if ({bus.clause_len_o, bus.var_value_o} !== 29'h0) begin
      errors++; $display("FAIL reset_data: got len %h vv %h want 0", bus.clause_len_o, bus.var_value_o);
    end
  endtask

  task automatic test_bin5();
    logic [4:0]  exp_len [8];
    logic [23:0] exp_vv [8];
    logic [7:0]  exp_wr;
    exp_len = '{5'd2, 5'd3, 5'd3, 5'd3, 5'd3, 5'd0, 5'd0, 5'd0};
    exp_vv  = '{24'h000042, 24'h000049, 24'h490000, 24'h200408, 24'h400011, 24'h0, 24'h0, 24'h0};
    mem[8'h10] = 16'h0012;   // {2,0,1,0,0,0,0,0}
    mem[8'h11] = 16'h0015;   // {1,1,1,0,0,0,0,0}
    mem[8'h12] = 16'hA800;   // {0,0,0,0,0,2,2,2}
    mem[8'h13] = 16'h70B7;   // {3,1,3,2,0,0,3,1}
    mem[8'h14] = 16'h8009;   // {1,2,0,0,0,0,0,2}
    mem[8'h15] = 16'hFFFF;
    mem[8'h16] = 16'hFFFF;
    mem[8'h17] = 16'hFFFF;
    mem_lat = 1;
    clear_logs();
    do_start(8'h10, 4'd5);
    wait_done(1, "bin5");
    checks++;
    if (done_cyc - start_cyc + 1 != 19) begin errors++; $display("FAIL bin5_done_cycle: got %0d want 19", done_cyc - start_cyc + 1); end
    checks++;
    if (wr_log.size() != 8) begin errors++; $display("FAIL bin5_write_count: got %0d want 8", wr_log.size()); end
    checks++;
    if (addr_log.size() != 5) begin errors++; $display("FAIL bin5_read_count: got %0d want 5", addr_log.size()); end
    checks++;
    if (multihot != 0) begin errors++; $display("FAIL bin5_multihot: got %0d want 0", multihot); end
    for (int i = 0; i < wr_log.size() && i < 8; i++) begin
      exp_wr = 8'h01 << i;
      checks++;
      if (wr_log[i] !== exp_wr) begin errors++; $display("FAIL bin5_wr[%0d]: got %h want %h", i, wr_log[i], exp_wr); end
      checks++;
      if (len_log[i] !== exp_len[i]) begin errors++; $display("FAIL bin5_len[%0d]: got %0d want %0d", i, len_log[i], exp_len[i]); end
      checks++;
      if (vv_log[i] !== exp_vv[i]) begin errors++; $display("FAIL bin5_vv[%0d]: got %h want %h", i, vv_log[i], exp_vv[i]); end
    end
    for (int i = 0; i < addr_log.size() && i < 5; i++) begin
      checks++;
      if (addr_log[i] !== 8'h10 + 8'(i)) begin errors++; $display("FAIL bin5_addr[%0d]: got %h want %h", i, addr_log[i], 8'h10 + 8'(i)); end
    end
  endtask

  task automatic test_learnt();
    bus.learnt_lits_i  = 16'h2411;   // {1,0,1,0,0,1,2,0}
    bus.insert_index_i = 8'b0010_0000;
    bus.learnt_req_i   = 1'b1;
    @(posedge clk);
    #1;
    bus.learnt_req_i = 1'b0;
    checks++;
    if (bus.wr_o !== 8'b0010_0000) begin errors++; $display("FAIL learnt_wr: got %b want 00100000", bus.wr_o); end
    checks++;
    if (bus.clause_len_o !== 5'd4) begin errors++; $display("FAIL learnt_len: got %0d want 4", bus.clause_len_o); end
    checks++;
    if (bus.var_value_o !== 24'h088041) begin errors++; $display("FAIL learnt_vv: got %h want 088041", bus.var_value_o); end
    checks++;
    if (bus.learnt_ack_o !== 1'b1) begin errors++; $display("FAIL learnt_ack: got %b want 1", bus.learnt_ack_o); end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.wr_o, bus.learnt_ack_o, bus.busy_o} !== 10'b0) begin
      errors++; $display("FAIL learnt_after: got wr %b ack %b busy %b want 0", bus.wr_o, bus.learnt_ack_o, bus.busy_o);
    end
    // Several free slots: the lowest one wins; reserved codes vanish
    bus.learnt_lits_i  = 16'h0003;
    bus.insert_index_i = 8'b1010_0100;
    bus.learnt_req_i   = 1'b1;
    @(posedge clk);
    #1;
    bus.learnt_req_i = 1'b0;
    checks++;
    if (bus.wr_o !== 8'b0000_0100) begin errors++; $display("FAIL learnt_lowest_wr: got %b want 00000100", bus.wr_o); end
    checks++;
    if ({bus.clause_len_o, bus.var_value_o} !== 29'h0) begin
      errors++; $display("FAIL learnt_code3: got len %0d vv %h want 0", bus.clause_len_o, bus.var_value_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_learnt_full();
    bus.insert_index_i = 8'h00;
    bus.learnt_req_i   = 1'b1;
    @(posedge clk);
    #1;
    bus.learnt_req_i = 1'b0;
    checks++;
    if (bus.learnt_full_o !== 1'b1) begin errors++; $display("FAIL full_pulse: got %b want 1", bus.learnt_full_o); end
    checks++;
    if ({bus.wr_o, bus.learnt_ack_o, bus.busy_o} !== 10'b0) begin
      errors++; $display("FAIL full_nowrite: got wr %b ack %b busy %b want 0", bus.wr_o, bus.learnt_ack_o, bus.busy_o);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.learnt_full_o !== 1'b0) begin errors++; $display("FAIL full_single: got %b want 0", bus.learnt_full_o); end
  endtask

  task automatic test_collision();
    clear_logs();
    bus.insert_index_i = 8'h01;
    bus.learnt_lits_i  = 16'h0001;
    bus.learnt_req_i   = 1'b1;
    do_start(8'h00, 4'd0);
    bus.learnt_req_i = 1'b0;
    @(posedge clk);
    #1;
    // Both requests again while busy: neither may be queued
    bus.start_i      = 1'b1;
    bus.learnt_req_i = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i      = 1'b0;
    bus.learnt_req_i = 1'b0;
    wait_done(1, "coll");
    checks++;
    if (done_cyc - start_cyc + 1 != 9) begin errors++; $display("FAIL coll_done_cycle: got %0d want 9", done_cyc - start_cyc + 1); end
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL coll_done_count: got %0d want 1", done_cnt); end
    checks++;
    if (ack_cnt != 0) begin errors++; $display("FAIL coll_ack_count: got %0d want 0", ack_cnt); end
    checks++;
    if (wr_log.size() != 8) begin errors++; $display("FAIL coll_write_count: got %0d want 8", wr_log.size()); end
    checks++;
    if (addr_log.size() != 0) begin errors++; $display("FAIL coll_read_count: got %0d want 0", addr_log.size()); end
    for (int i = 0; i < wr_log.size() && i < 8; i++) begin
      checks++;
      if ({len_log[i], vv_log[i]} !== 29'h0) begin errors++; $display("FAIL coll_clear[%0d]: got len %0d vv %h want 0", i, len_log[i], vv_log[i]); end
    end
  endtask

  task automatic test_full8();
    logic [4:0]  exp_len [8];
    logic [23:0] exp_vv [3];
    logic [7:0]  exp_a;
    exp_len = '{5'd8, 5'd8, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    exp_vv  = '{24'h249249, 24'h492492, 24'h000001};
    mem[8'hFE] = 16'h5555;
    mem[8'hFF] = 16'hAAAA;
    mem[8'h00] = 16'h0001;
    for (int a = 1; a <= 5; a++) mem[a] = 16'hFFFF;
    mem_lat = 3;
    clear_logs();
    do_start(8'hFE, 4'd12);
    wait_done(1, "full8");
    checks++;
    if (done_cyc - start_cyc + 1 != 41) begin errors++; $display("FAIL full8_done_cycle: got %0d want 41", done_cyc - start_cyc + 1); end
    checks++;
    if (wr_log.size() != 8) begin errors++; $display("FAIL full8_write_count: got %0d want 8", wr_log.size()); end
    checks++;
    if (addr_log.size() != 8) begin errors++; $display("FAIL full8_read_count: got %0d want 8", addr_log.size()); end
    checks++;
    if (multihot != 0) begin errors++; $display("FAIL full8_multihot: got %0d want 0", multihot); end
    for (int i = 0; i < wr_log.size() && i < 8; i++) begin
      checks++;
      if (wr_log[i] !== (8'h01 << i)) begin errors++; $display("FAIL full8_wr[%0d]: got %h", i, wr_log[i]); end
      checks++;
      if (len_log[i] !== exp_len[i]) begin errors++; $display("FAIL full8_len[%0d]: got %0d want %0d", i, len_log[i], exp_len[i]); end
      if (i < 3) begin
        checks++;
        if (vv_log[i] !== exp_vv[i]) begin errors++; $display("FAIL full8_vv[%0d]: got %h want %h", i, vv_log[i], exp_vv[i]); end
      end
    end
    for (int i = 0; i < addr_log.size() && i < 8; i++) begin
      exp_a = 8'hFE + 8'(i);
      checks++;
      if (addr_log[i] !== exp_a) begin errors++; $display("FAIL full8_addr[%0d]: got %h want %h", i, addr_log[i], exp_a); end
    end
  endtask

  task automatic test_reset_mid();
    mem_lat = 3;
    clear_logs();
    do_start(8'h10, 4'd3);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.busy_o, bus.mem_rd_o, bus.done_o} !== 3'b0) begin
      errors++; $display("FAIL rstmid_flags: got busy %b rd %b done %b want 0", bus.busy_o, bus.mem_rd_o, bus.done_o);
    end
    checks++;
    if ({bus.wr_o, bus.mem_addr_o} !== 16'h0) begin
      errors++; $display("FAIL rstmid_bus: got wr %h addr %h want 0", bus.wr_o, bus.mem_addr_o);
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (wr_log.size() != 0) begin errors++; $display("FAIL rstmid_late_rvalid: got %0d writes want 0", wr_log.size()); end
    checks++;
    if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got busy %b want 0", bus.busy_o); end
    mem_lat = 1;
    clear_logs();
    do_start(8'h10, 4'd5);
    wait_done(1, "rstmid_reload");
    checks++;
    if (done_cyc - start_cyc + 1 != 19) begin errors++; $display("FAIL rstmid_done_cycle: got %0d want 19", done_cyc - start_cyc + 1); end
    checks++;
    if (wr_log.size() != 8) begin errors++; $display("FAIL rstmid_write_count: got %0d want 8", wr_log.size()); end
    if (wr_log.size() > 0) begin
      checks++;
      if ({wr_log[0], len_log[0]} !== {8'h01, 5'd2}) begin
        errors++; $display("FAIL rstmid_row0: got wr %h len %0d want 01 len 2", wr_log[0], len_log[0]);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 16'h0;
    bus.start_i        = 1'b0;
    bus.base_addr_i    = '0;
    bus.n_clauses_i    = '0;
    bus.mem_rdata_i    = '0;
    bus.mem_rvalid_i   = 1'b0;
    bus.learnt_req_i   = 1'b0;
    bus.learnt_lits_i  = '0;
    bus.insert_index_i = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    test_bin5();
    test_learnt();
    test_learnt_full();
    test_collision();
    test_full8();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
